// File: rtl/dpe_scan_frame_loader.sv
// Scan-chain SRAM loader: captures serial frames on SC_CLK/SC_EN and emits one buffered write per valid frame.
// Optional odd-parity bit per frame when SCAN_PARITY_EN is defined.
module dpe_scan_frame_loader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SC_CLK,
  input  logic              SC_EN,
  input  logic              scanIn,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_init_done,
  output logic [ERR_W-1:0]  o_frame_err,
  output logic [ERR_W-1:0]  o_overrun_err
);

`ifdef SCAN_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + ADDR_W + 2;
`else
  localparam int unsigned FRAME_W = DATA_W + ADDR_W + 1;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_W + 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STG-1:0] sen_sync_q, sen_sync_d;
  logic [SYNC_STG-1:0] din_sync_q, din_sync_d;
  logic                sclk_prev_q, sclk_prev_d;
  logic                sen_prev_q, sen_prev_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                init_done_q, init_done_d;
  logic [ERR_W-1:0]    frame_err_q, frame_err_d;
  logic [ERR_W-1:0]    overrun_err_q, overrun_err_d;

  logic sclk_s, sen_s, din_s, rise, commit;
  logic parity_ok, frame_ok, all_ones;

  // Matched synchroniser pipelines keep data aligned with its scan clock.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], SC_CLK};
    sen_sync_d  = {sen_sync_q[SYNC_STG-2:0], SC_EN};
    din_sync_d  = {din_sync_q[SYNC_STG-2:0], scanIn};
    sclk_s      = sclk_sync_q[SYNC_STG-1];
    sen_s       = sen_sync_q[SYNC_STG-1];
    din_s       = din_sync_q[SYNC_STG-1];
    sclk_prev_d = sclk_s;
    sen_prev_d  = sen_s;
    rise        = sclk_s & ~sclk_prev_q;
    commit      = ~sen_s & sen_prev_q;
  end

  always_comb begin
`ifdef SCAN_PARITY_EN
    parity_ok = ^shift_q[FRAME_W-2:0];
`else
    parity_ok = 1'b1;
`endif
    frame_ok = (bitcnt_q == CNT_W'(FRAME_W)) && shift_q[FRAME_W-1] && parity_ok;
    all_ones = &shift_q[DATA_W+ADDR_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    wr_valid_d    = wr_valid_q & ~i_wr_ready;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    init_done_d   = init_done_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;

    case (state_q)
      S_IDLE, S_SHIFT: begin
        if (commit) begin
          state_d = S_CHECK;
        end else if (rise && sen_s) begin
          for (int unsigned i = 0; i < FRAME_W; i++) begin
            if (CNT_W'(i) == bitcnt_q) shift_d[i] = din_s;
          end
          // Saturate one past a full frame so overlong frames stay detectable.
          if (bitcnt_q != CNT_W'(FRAME_W + 1)) bitcnt_d = bitcnt_q + CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_CHECK: begin
        state_d  = S_IDLE;
        bitcnt_d = '0;
        shift_d  = '0;
        if (!frame_ok) begin
          if (frame_err_q != '1) frame_err_d = frame_err_q + ERR_W'(1);
        end else if (all_ones) begin
          init_done_d = 1'b1;
          state_d     = S_DONE;
        end else if (wr_valid_q && !i_wr_ready) begin
          if (overrun_err_q != '1) overrun_err_d = overrun_err_q + ERR_W'(1);
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = shift_q[DATA_W +: ADDR_W];
          wr_data_d  = shift_q[DATA_W-1:0];
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= '0;
      sen_sync_q    <= '0;
      din_sync_q    <= '0;
      sclk_prev_q   <= 1'b0;
      sen_prev_q    <= 1'b0;
      shift_q       <= '0;
      bitcnt_q      <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      init_done_q   <= 1'b0;
      frame_err_q   <= '0;
      overrun_err_q <= '0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      sen_sync_q    <= sen_sync_d;
      din_sync_q    <= din_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      sen_prev_q    <= sen_prev_d;
      shift_q       <= shift_d;
      bitcnt_q      <= bitcnt_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      init_done_q   <= init_done_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign o_wr_valid    = wr_valid_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_init_done   = init_done_q;
  assign o_frame_err   = frame_err_q;
  assign o_overrun_err = overrun_err_q;

endmodule

// File: tb/tb_dpe_scan_frame_loader.sv
// Directed bench for dpe_scan_frame_loader: vector table plus hand sequences for back-pressure, reset and init.
module tb_dpe_scan_frame_loader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SS = 2;
  localparam int EW = 8;
`ifdef SCAN_PARITY_EN
  localparam int FW = DW + AW + 2;
`else
  localparam int FW = DW + AW + 1;
`endif

  logic          CLK = 1'b0;
  logic          RST, SC_CLK, SC_EN, scanIn, i_wr_ready;
  logic          o_wr_valid, o_init_done;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic [EW-1:0] o_frame_err, o_overrun_err;

  dpe_scan_frame_loader #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STG(SS), .ERR_W(EW)) dut (
    .CLK(CLK), .RST(RST), .SC_CLK(SC_CLK), .SC_EN(SC_EN), .scanIn(scanIn),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_init_done(o_init_done), .o_frame_err(o_frame_err),
    .o_overrun_err(o_overrun_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic          held = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  // Scoreboard of completed transfers plus stability check while stalled.
  always @(negedge CLK) begin
    if (RST) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (o_wr_valid !== 1'b1 || o_wr_addr !== held_addr || o_wr_data !== held_data) begin
          fails++;
          $display("FAIL hold_stable: got v=%0b a=%0h d=%0h, required v=1 a=%0h d=%0h",
                   o_wr_valid, o_wr_addr, o_wr_data, held_addr, held_data);
        end
      end
      if (o_wr_valid === 1'b1 && i_wr_ready === 1'b1) begin
        wr_count++;
        last_addr = o_wr_addr;
        last_data = o_wr_data;
      end
      held      = (o_wr_valid === 1'b1) && !i_wr_ready;
      held_addr = o_wr_addr;
      held_data = o_wr_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    SC_EN = 1'b1;
    cyc(6);
    for (int i = 0; i < n; i++) begin
      scanIn = bits[i];
      cyc(3);
      SC_CLK = 1'b1;
      cyc(6);
      SC_CLK = 1'b0;
      cyc(3);
    end
  endtask

  task automatic commit(output int lat);
    lat = -1;
    SC_EN = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      cyc(1);
      if (lat < 0 && o_wr_valid === 1'b1) lat = c;
    end
  endtask

  function automatic logic [63:0] mk(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic stop);
`ifdef SCAN_PARITY_EN
    mk = {22'b0, stop, ~^{a, d}, a, d};
`else
    mk = {23'b0, stop, a, d};
`endif
  endfunction

  typedef struct {
    logic [63:0]   bits;
    int            n;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int wc;
    int fe;

    vecs[0] = '{mk(32'h03020100, 8'h21, 1'b1), FW, 1'b1, 8'h21, 32'h03020100, 0};
    vecs[1] = '{mk(32'h03020100, 8'h21, 1'b1) >> 1, FW - 1, 1'b0, 8'h00, 32'h0, 1};
    vecs[2] = '{mk(32'h03020100, 8'h21, 1'b0), FW, 1'b0, 8'h00, 32'h0, 2};
    vecs[3] = '{mk(32'hDEADBEEF, 8'hA5, 1'b1), FW, 1'b1, 8'hA5, 32'hDEADBEEF, 2};
    vecs[4] = '{64'h0, 0, 1'b0, 8'h00, 32'h0, 3};
    vecs[5] = '{mk(32'h12345678, 8'h3C, 1'b1), FW + 3, 1'b0, 8'h00, 32'h0, 4};

    RST = 1'b1; SC_CLK = 1'b0; SC_EN = 1'b0; scanIn = 1'b0; i_wr_ready = 1'b1;
    cyc(5);
    chk("rst_valid", 64'(o_wr_valid), 64'd0);
    chk("rst_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_data", 64'(o_wr_data), 64'd0);
    chk("rst_init", 64'(o_init_done), 64'd0);
    chk("rst_ferr", 64'(o_frame_err), 64'd0);
    chk("rst_ovr", 64'(o_overrun_err), 64'd0);
    RST = 1'b0;
    cyc(2);

    foreach (vecs[k]) begin
      wc = wr_count;
      send_bits(vecs[k].bits, vecs[k].n);
      commit(lat);
      chk($sformatf("vec%0d_writes", k), 64'(wr_count - wc), 64'(vecs[k].wr));
      if (vecs[k].wr) begin
        chk($sformatf("vec%0d_addr", k), 64'(last_addr), 64'(vecs[k].a));
        chk($sformatf("vec%0d_data", k), 64'(last_data), 64'(vecs[k].d));
        chk($sformatf("vec%0d_latency", k), 64'(lat), 64'(SS + 2));
      end
      chk($sformatf("vec%0d_ferr", k), 64'(o_frame_err), 64'(vecs[k].ferr));
      chk($sformatf("vec%0d_ovr", k), 64'(o_overrun_err), 64'd0);
      chk($sformatf("vec%0d_valid_clr", k), 64'(o_wr_valid), 64'd0);
    end

    // Back-pressure: second frame overruns, first stays pending until ready.
    i_wr_ready = 1'b0;
    wc = wr_count;
    send_bits(mk(32'h03020100, 8'h21, 1'b1), FW);
    commit(lat);
    chk("bp_valid", 64'(o_wr_valid), 64'd1);
    chk("bp_addr", 64'(o_wr_addr), 64'h21);
    chk("bp_data", 64'(o_wr_data), 64'h03020100);
    send_bits(mk(32'h0A0B0C0D, 8'h22, 1'b1), FW);
    commit(lat);
    chk("bp_overrun", 64'(o_overrun_err), 64'd1);
    chk("bp_addr_kept", 64'(o_wr_addr), 64'h21);
    chk("bp_no_write", 64'(wr_count - wc), 64'd0);
    i_wr_ready = 1'b1;
    cyc(3);
    chk("bp_one_write", 64'(wr_count - wc), 64'd1);
    chk("bp_written_addr", 64'(last_addr), 64'h21);
    chk("bp_written_data", 64'(last_data), 64'h03020100);
    chk("bp_valid_clr", 64'(o_wr_valid), 64'd0);

`ifdef SCAN_PARITY_EN
    fe = int'(o_frame_err);
    wc = wr_count;
    send_bits({22'b0, 1'b1, 1'b0, 8'h00, 32'h1}, FW);
    commit(lat);
    chk("par_good_write", 64'(wr_count - wc), 64'd1);
    chk("par_good_data", 64'(last_data), 64'h1);
    send_bits({22'b0, 1'b1, 1'b1, 8'h00, 32'h1}, FW);
    commit(lat);
    chk("par_bad_nowrite", 64'(wr_count - wc), 64'd1);
    chk("par_bad_ferr", 64'(o_frame_err), 64'(fe + 1));
`endif

    // Reset mid-frame discards everything.
    send_bits(mk(32'hCAFEF00D, 8'h44, 1'b1), 20);
    RST = 1'b1; SC_EN = 1'b0; SC_CLK = 1'b0; scanIn = 1'b0;
    cyc(6);
    chk("mid_rst_valid", 64'(o_wr_valid), 64'd0);
    chk("mid_rst_addr", 64'(o_wr_addr), 64'd0);
    chk("mid_rst_data", 64'(o_wr_data), 64'd0);
    chk("mid_rst_ferr", 64'(o_frame_err), 64'd0);
    chk("mid_rst_ovr", 64'(o_overrun_err), 64'd0);
    RST = 1'b0;
    cyc(2);
    wc = wr_count;
    send_bits(mk(32'hFF060504, 8'h30, 1'b1), FW);
    commit(lat);
    chk("post_rst_writes", 64'(wr_count - wc), 64'd1);
    chk("post_rst_addr", 64'(last_addr), 64'h30);
    chk("post_rst_data", 64'(last_data), 64'hFF060504);
    chk("post_rst_ferr", 64'(o_frame_err), 64'd0);

    // End-of-init frame, then everything is ignored.
    wc = wr_count;
    send_bits(mk('1, '1, 1'b1), FW);
    commit(lat);
    chk("init_done", 64'(o_init_done), 64'd1);
    chk("init_no_write", 64'(wr_count - wc), 64'd0);
    send_bits(mk(32'h00000011, 8'h05, 1'b1), FW);
    commit(lat);
    chk("done_ignore_write", 64'(wr_count - wc), 64'd0);
    chk("done_init_sticky", 64'(o_init_done), 64'd1);
    send_bits(64'h1F, 5);
    commit(lat);
    chk("done_ferr_frozen", 64'(o_frame_err), 64'd0);
    chk("done_valid", 64'(o_wr_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
